// File: rtl/mult8_seq_ctrl.sv
// Sequenced 8x8 -> 16-bit unsigned multiplier that reuses one 4x4 Wallace tree over four nibble steps.
// Optional build macro MULT8_EARLY_EXIT_EN: skip steps whose selected nibble pair has a zero nibble.

module fourbitwallace_tree (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_prod
);

   logic [3:0] w_pp [4];
   logic [1:0] w_h11, w_f12, w_f13, w_f14, w_h15;
   logic [1:0] w_h22, w_f23, w_h24, w_h25, w_h26;
   logic [7:0] w_rowA, w_rowB;

   // Adder cells return {carry, sum}
   function automatic logic [1:0] halfAdd(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   function automatic logic [1:0] fullAdd(input logic x, input logic y, input logic z);
      return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
   endfunction

   // w_pp[j][i] is a[i] & b[j], weight 2^(i+j)
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            w_pp[j][i] = i_a[i] & i_b[j];
         end
      end
   end

   assign w_h11 = halfAdd(w_pp[0][1], w_pp[1][0]);
   assign w_f12 = fullAdd(w_pp[0][2], w_pp[1][1], w_pp[2][0]);
   assign w_f13 = fullAdd(w_pp[0][3], w_pp[1][2], w_pp[2][1]);
   assign w_f14 = fullAdd(w_pp[1][3], w_pp[2][2], w_pp[3][1]);
   assign w_h15 = halfAdd(w_pp[2][3], w_pp[3][2]);

   assign w_h22 = halfAdd(w_f12[0], w_h11[1]);
   assign w_f23 = fullAdd(w_f13[0], w_pp[3][0], w_f12[1]);
   assign w_h24 = halfAdd(w_f14[0], w_f13[1]);
   assign w_h25 = halfAdd(w_h15[0], w_f14[1]);
   assign w_h26 = halfAdd(w_pp[3][3], w_h15[1]);

   // Two remaining rows meet in a final carry-propagate add; the product never exceeds 8 bits
   assign w_rowA = {w_h26[1], w_h26[0], w_h25[0], w_h24[0], w_f23[0], w_h22[0], w_h11[0], w_pp[0][0]};
   assign w_rowB = {1'b0, w_h25[1], w_h24[1], w_f23[1], w_h22[1], 3'b000};
   assign o_prod = w_rowA + w_rowB;

endmodule

module mult8_seq_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  multiplicand,
   input  logic [7:0]  multiplier,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [7:0]  r_aQ;
   logic [7:0]  r_bQ;
   logic [15:0] r_acc;
   logic [1:0]  r_step;
   logic [15:0] r_result;

   logic [3:0]  w_nibA;
   logic [3:0]  w_nibB;
   logic [3:0]  w_shift;
   logic [7:0]  w_prod;
   logic [15:0] w_accNext;
   logic [1:0]  w_startStep;
   logic [1:0]  w_nextStep;
   logic        w_lastStep;

   always_comb begin
      w_nibA  = r_aQ[3:0];
      w_nibB  = r_bQ[3:0];
      w_shift = 4'd0;
      case (r_step)
         2'd1: begin
            w_nibA  = r_aQ[7:4];
            w_shift = 4'd4;
         end
         2'd2: begin
            w_nibB  = r_bQ[7:4];
            w_shift = 4'd4;
         end
         2'd3: begin
            w_nibA  = r_aQ[7:4];
            w_nibB  = r_bQ[7:4];
            w_shift = 4'd8;
         end
         default: ;
      endcase
   end

   fourbitwallace_tree u_tree (
      .i_a    (w_nibA),
      .i_b    (w_nibB),
      .o_prod (w_prod)
   );

   assign w_accNext = r_acc + ({8'b0, w_prod} << w_shift);

`ifdef MULT8_EARLY_EXIT_EN
   logic [3:0] w_inMask;
   logic [3:0] w_curMask;
   logic [3:0] w_aboveMask;

   // Bit k set means step k has two nonzero nibbles and contributes to the product
   function automatic logic [3:0] stepMask(input logic [7:0] a, input logic [7:0] b);
      return {(|a[7:4]) & (|b[7:4]),
              (|a[3:0]) & (|b[7:4]),
              (|a[7:4]) & (|b[3:0]),
              (|a[3:0]) & (|b[3:0])};
   endfunction

   function automatic logic [1:0] lowestSet(input logic [3:0] m);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   assign w_inMask    = stepMask(multiplicand, multiplier);
   assign w_curMask   = stepMask(r_aQ, r_bQ);
   assign w_aboveMask = w_curMask & (4'b1110 << r_step);
   assign w_startStep = lowestSet(w_inMask);
   assign w_nextStep  = lowestSet(w_aboveMask);
   assign w_lastStep  = ~|w_aboveMask;
`else
   assign w_startStep = 2'd0;
   assign w_nextStep  = r_step + 2'd1;
   assign w_lastStep  = (r_step == 2'd3);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (start) w_stateNext = RUN;
         RUN:     if (w_lastStep) w_stateNext = DONE;
         DONE:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Result is written on the final RUN edge so it is already valid in the done cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         r_aQ     <= 8'd0;
         r_bQ     <= 8'd0;
         r_acc    <= 16'd0;
         r_step   <= 2'd0;
         r_result <= 16'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_aQ   <= multiplicand;
                  r_bQ   <= multiplier;
                  r_acc  <= 16'd0;
                  r_step <= w_startStep;
               end
            end
            RUN: begin
               r_acc <= w_accNext;
               if (w_lastStep) begin
                  r_result <= w_accNext;
               end else begin
                  r_step <= w_nextStep;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (r_state == RUN);
   assign done   = (r_state == DONE);
   assign result = r_result;

endmodule
